// File: rtl/memory_stage.sv
// RV64 MEM stage: aligns store data/byte enables, issues dmem requests over a
// valid/ready channel, extends load data and registers results into WB_*.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_V,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_PC,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  input  logic        MEM_ECALL,
  output logic        MEM_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        WB_V,
  output logic        WB_ECALL,
  output logic        WB_EXC,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_PC,
  output logic [63:0] WB_DATA,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic        v;
    logic        ecall;
    logic        exc;
    logic [31:0] ir;
    logic [63:0] pc;
    logic [63:0] data;
    logic [63:0] csrfd;
    logic [63:0] rfd;
  } wb_t;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  wb_t         wb_q, wb_d;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [2:0]  off;
  logic        is_ld, is_st, mem_op;
  logic        legal, aligned, fault, go;
  logic [7:0]  mask;
  logic [63:0] rsp_sh, rsp_ext;
  logic        stall_c;

  assign opcode = MEM_IR[6:0];
  assign f3     = MEM_IR[14:12];
  assign off    = MEM_ALU_RESULT[2:0];
  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign mem_op = MEM_V & (is_ld | is_st);

  // Width legality and natural alignment; funct3[1:0] encodes log2(bytes).
  always_comb begin
    legal = is_ld ? (f3 != 3'd7) : ~f3[2];
    case (f3[1:0])
      2'd0:    begin aligned = 1'b1;             mask = 8'h01; end
      2'd1:    begin aligned = ~off[0];          mask = 8'h03; end
      2'd2:    begin aligned = (off[1:0] == 2'd0); mask = 8'h0F; end
      default: begin aligned = (off == 3'd0);    mask = 8'hFF; end
    endcase
  end

  assign fault = mem_op & ~(legal & aligned);
  assign go    = mem_op & ~fault;

  assign rsp_sh = dmem_rdata >> {off_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'd0:    rsp_ext = {{56{rsp_sh[7]}},  rsp_sh[7:0]};
      3'd1:    rsp_ext = {{48{rsp_sh[15]}}, rsp_sh[15:0]};
      3'd2:    rsp_ext = {{32{rsp_sh[31]}}, rsp_sh[31:0]};
      3'd4:    rsp_ext = {56'd0, rsp_sh[7:0]};
      3'd5:    rsp_ext = {48'd0, rsp_sh[15:0]};
      3'd6:    rsp_ext = {32'd0, rsp_sh[31:0]};
      default: rsp_ext = rsp_sh;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE:    stall_c = go;
      REQ:     stall_c = ~(dmem_req_ready & we_q);
      WAIT:    stall_c = ~dmem_rsp_valid;
      default: stall_c = 1'b0;
    endcase
  end

  // Held low while reset is asserted so execute is never frozen by a stale op.
  assign MEM_stall = reset & stall_c;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = REQ;
        we_d    = is_st;
        addr_d  = {MEM_ALU_RESULT[63:3], 3'b000};
        wdata_d = MEM_SR2 << {off, 3'b000};
        be_d    = mask << off;
        off_d   = off;
        f3_d    = f3;
      end
      REQ:  if (dmem_req_ready) state_d = we_q ? IDLE : WAIT;
      WAIT: if (dmem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Execute holds MEM_* while stalled, so pass-through fields are valid at completion.
  always_comb begin
    wb_d = wb_q;
    if (stall_c) begin
      wb_d.v = 1'b0;
    end else begin
      wb_d.v     = MEM_V;
      wb_d.ecall = MEM_ECALL;
      wb_d.exc   = 1'b0;
      wb_d.ir    = MEM_IR;
      wb_d.pc    = MEM_PC;
      wb_d.data  = MEM_ALU_RESULT;
      wb_d.csrfd = MEM_CSRFD;
      wb_d.rfd   = MEM_RFD;
      if (state_q == IDLE && fault) begin
        wb_d.exc  = 1'b1;
        wb_d.data = 64'd0;
      end else if (state_q == WAIT) begin
        wb_d.data = rsp_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      be_q    <= 8'd0;
      off_q   <= 3'd0;
      f3_q    <= 3'd0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wb_q    <= wb_d;
    end
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;

  assign WB_V     = wb_q.v;
  assign WB_ECALL = wb_q.ecall;
  assign WB_EXC   = wb_q.exc;
  assign WB_IR    = wb_q.ir;
  assign WB_PC    = wb_q.pc;
  assign WB_DATA  = wb_q.data;
  assign WB_CSRFD = wb_q.csrfd;
  assign WB_RFD   = wb_q.rfd;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, loads, stores, faults, reset.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_PC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
  logic        MEM_ECALL;
  logic        MEM_stall;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic        WB_V, WB_ECALL, WB_EXC;
  logic [31:0] WB_IR;
  logic [63:0] WB_PC, WB_DATA, WB_CSRFD, WB_RFD;

  int total = 0;
  int bad   = 0;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_PC(MEM_PC),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL),
    .MEM_stall(MEM_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .WB_V(WB_V), .WB_ECALL(WB_ECALL), .WB_EXC(WB_EXC), .WB_IR(WB_IR),
    .WB_PC(WB_PC), .WB_DATA(WB_DATA), .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sr2);
    MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_SR2 = sr2;
    MEM_PC = 64'h8000_0000; MEM_CSRFD = 64'd0; MEM_RFD = 64'd0; MEM_ECALL = 1'b0;
  endtask

  task automatic nop();
    MEM_V = 1'b0; MEM_IR = 32'h0000_0013; MEM_ALU_RESULT = 64'd0; MEM_SR2 = 64'd0;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; nop();
    MEM_PC = 64'd0; MEM_CSRFD = 64'd0; MEM_RFD = 64'd0; MEM_ECALL = 1'b0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 64'd0;
    #12;
    chk("rst_wb_v", 64'(WB_V), 64'd0);
    chk("rst_stall", 64'(MEM_stall), 64'd0);
    chk("rst_req", 64'(dmem_req_valid), 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    @(negedge clk); reset = 1'b1;

    // ADD pass-through
    @(negedge clk); drive(32'h0000_0033, 64'h1234, 64'd0); #1;
    chk("add_stall", 64'(MEM_stall), 64'd0);
    after_edge();
    chk("add_wb_v", 64'(WB_V), 64'd1);
    chk("add_wb_data", WB_DATA, 64'h1234);
    chk("add_wb_exc", 64'(WB_EXC), 64'd0);

    // LB at 0x1003, ready=1, response one cycle after accept
    @(negedge clk); drive(32'h0000_0003, 64'h1003, 64'd0); #1;
    chk("lb_c0_stall", 64'(MEM_stall), 64'd1);
    chk("lb_c0_req", 64'(dmem_req_valid), 64'd0);
    after_edge();
    chk("lb_c1_wb_v", 64'(WB_V), 64'd0);
    chk("lb_c1_req", 64'(dmem_req_valid), 64'd1);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_be", 64'(dmem_be), 64'h08);
    chk("lb_we", 64'(dmem_we), 64'd0);
    @(negedge clk); #1;
    chk("lb_c1_stall", 64'(MEM_stall), 64'd1);
    after_edge();
    chk("lb_c2_wb_v", 64'(WB_V), 64'd0);
    chk("lb_c2_req", 64'(dmem_req_valid), 64'd0);
    @(negedge clk); dmem_rsp_valid = 1'b1; dmem_rdata = 64'h0000_0000_80FF_0000; #1;
    chk("lb_c2_stall", 64'(MEM_stall), 64'd0);
    after_edge();
    chk("lb_wb_v", 64'(WB_V), 64'd1);
    chk("lb_wb_data", WB_DATA, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk); dmem_rsp_valid = 1'b0; nop();
    after_edge();
    chk("lb_wb_v_once", 64'(WB_V), 64'd0);

    // SH at 0x2006 with ready low for 3 cycles
    @(negedge clk); dmem_req_ready = 1'b0; drive(32'h0000_1023, 64'h2006, 64'hBEEF); #1;
    chk("sh_c0_stall", 64'(MEM_stall), 64'd1);
    after_edge();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("sh_bp_req", 64'(dmem_req_valid), 64'd1);
      chk("sh_bp_be", 64'(dmem_be), 64'hC0);
      chk("sh_bp_wdata", dmem_wdata, 64'hBEEF_0000_0000_0000);
      chk("sh_bp_stall", 64'(MEM_stall), 64'd1);
      after_edge();
      chk("sh_bp_wb_v", 64'(WB_V), 64'd0);
    end
    @(negedge clk); dmem_req_ready = 1'b1; #1;
    chk("sh_acc_stall", 64'(MEM_stall), 64'd0);
    chk("sh_acc_we", 64'(dmem_we), 64'd1);
    chk("sh_acc_addr", dmem_addr, 64'h2000);
    after_edge();
    chk("sh_wb_v", 64'(WB_V), 64'd1);
    chk("sh_wb_exc", 64'(WB_EXC), 64'd0);
    chk("sh_req_done", 64'(dmem_req_valid), 64'd0);
    @(negedge clk); nop();

    // LW misaligned
    @(negedge clk); drive(32'h0000_2003, 64'h3002, 64'd0); #1;
    chk("lwmis_stall", 64'(MEM_stall), 64'd0);
    chk("lwmis_req", 64'(dmem_req_valid), 64'd0);
    after_edge();
    chk("lwmis_wb_v", 64'(WB_V), 64'd1);
    chk("lwmis_wb_exc", 64'(WB_EXC), 64'd1);
    chk("lwmis_wb_data", WB_DATA, 64'd0);
    chk("lwmis_req2", 64'(dmem_req_valid), 64'd0);
    @(negedge clk); nop();

    // LWU at 0x4004
    @(negedge clk); drive(32'h0000_6003, 64'h4004, 64'd0);
    after_edge();
    after_edge();
    @(negedge clk); dmem_rsp_valid = 1'b1; dmem_rdata = 64'hF000_0001_0000_0000;
    after_edge();
    chk("lwu_wb_v", 64'(WB_V), 64'd1);
    chk("lwu_wb_data", WB_DATA, 64'h0000_0000_F000_0001);
    @(negedge clk); dmem_rsp_valid = 1'b0; nop();

    // LD interrupted by reset in WAIT, then a spurious response
    @(negedge clk); drive(32'h0000_3003, 64'h5000, 64'd0);
    after_edge();
    after_edge();
    @(negedge clk); #1;
    chk("ld_wait_stall", 64'(MEM_stall), 64'd1);
    #1 reset = 1'b0; #1;
    chk("ldrst_stall", 64'(MEM_stall), 64'd0);
    chk("ldrst_req", 64'(dmem_req_valid), 64'd0);
    chk("ldrst_addr", dmem_addr, 64'd0);
    chk("ldrst_wb_data", WB_DATA, 64'd0);
    chk("ldrst_wb_v", 64'(WB_V), 64'd0);
    @(negedge clk); reset = 1'b1; nop();
    dmem_rsp_valid = 1'b1; dmem_rdata = 64'h1122_3344_5566_7788; #1;
    chk("ldrst_post_stall", 64'(MEM_stall), 64'd0);
    after_edge();
    chk("ldrst_post_wb_v", 64'(WB_V), 64'd0);
    chk("ldrst_post_req", 64'(dmem_req_valid), 64'd0);
    chk("ldrst_post_data", WB_DATA, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the RV64 core; it consumes the execute stage's MEM_* register outputs and drives MEM_stall back to execute. Loads and stores go to data memory over a valid/ready request channel and a valid response channel. The stage aligns store data and byte enables, and it extracts and sign- or zero-extends load data. Results, together with pass-through fields, are registered into WB_* for writeback.

## Interface
- No parameters. XLEN is fixed at 64; the data bus is 64 bits with 8 byte lanes.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- MEM_V  in  1  instruction in MEM is valid
- MEM_IR  in  32  instruction; opcode [6:0], funct3 [14:12]
- MEM_PC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD  in  64 each  from execute; ALU_RESULT is the effective address for load/store
- MEM_ECALL  in  1  ecall flag
- MEM_stall  out  1  combinational; high means execute must hold its MEM_* outputs
- dmem_req_valid  out  1; dmem_req_ready  in  1
- dmem_we  out  1  1 = store
- dmem_addr  out  64  doubleword-aligned address, {addr[63:3],3'b0}
- dmem_wdata  out  64; dmem_be  out  8  byte enables
- dmem_rsp_valid  in  1; dmem_rdata  in  64  response for loads only
- WB_V, WB_ECALL, WB_EXC  out  1 each  WB_EXC = misaligned access or illegal width
- WB_IR  out  32; WB_PC, WB_DATA, WB_CSRFD, WB_RFD  out  64 each

## Operation
- Memory op: MEM_V=1 and opcode is 0000011 (load) or 0100011 (store). Every other case is a pass-through.
- Pass-through: no stall. On each edge:
  - WB_V<=MEM_V.
  - WB_DATA<=MEM_ALU_RESULT.
  - WB_IR/PC/CSRFD/RFD/ECALL<=the corresponding MEM_* input.
  - WB_EXC<=0.
- Width and alignment check (off = addr[2:0]):
  - Loads: funct3 0/4 = byte, 1/5 = half (off[0]=0), 2/6 = word (off[1:0]=0), 3 = double (off=0).
  - Stores: funct3 0..3, same widths.
  - Load funct3 7, store funct3 4..7, or any misalignment is a fault.
  - Fault: no memory request and no stall. The instruction retires in one cycle with WB_V=1, WB_EXC=1, WB_DATA=0.
- FSM states IDLE, REQ, WAIT.
  - IDLE: a valid, aligned memory op asserts MEM_stall and moves to REQ.
  - On the IDLE→REQ edge the stage latches dmem_addr, dmem_we, dmem_be = (width mask)<<off, and dmem_wdata = MEM_SR2<<(8*off).
  - REQ: dmem_req_valid=1 and all request fields are held stable until dmem_req_ready=1. On acceptance:
    - Store: completes in the accept cycle, writes WB, then returns to IDLE.
    - Load: moves to WAIT.
  - WAIT: on dmem_rsp_valid=1, WB_DATA<=extend(dmem_rdata>>(8*off)), WB is written, and the FSM returns to IDLE.
  - Load extension: sign-extend for funct3 0/1/2, zero-extend for 4/5/6, no extension for LD.
- MEM_stall = (IDLE & aligned mem op) | (REQ & !(ready & we)) | (WAIT & !rsp_valid).
  - It is low in the completion cycle, so execute advances on that same edge.
- While MEM_stall=1, WB_V<=0 on every edge (bubble). WB_V=1 exactly once per retired instruction.
- dmem_rsp_valid is ignored outside WAIT.
- dmem_req_valid is never high outside REQ.

## Timing
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - MEM_stall=0 and dmem_req_valid=0.
  - dmem_we, addr, wdata, be = 0.
  - All WB_* = 0.
- Reset mid-transaction abandons the request immediately; a later response is ignored because the FSM is in IDLE.
- Pass-through latency: 1 cycle from MEM_* to WB_*.
- Load latency with ready=1 and the response one cycle after accept: 3 cycles.
  - c0: IDLE, stall=1.
  - c1: REQ, req_valid=1, accept.
  - c2: WAIT, rsp_valid=1, stall=0, WB written at the end of c2.
- Store latency with ready=1: 2 cycles (c0 IDLE, c1 accept and retire).
- Each cycle dmem_req_ready is low adds one cycle. Each cycle dmem_rsp_valid is late adds one cycle.
- Back-to-back memory ops: after completion the FSM is in IDLE, so the next op starts its c0 on the following cycle. There is no overlap.

## Test plan
- ADD pass-through: MEM_V=1, opcode 0110011, ALU_RESULT=0x1234. Required: next cycle WB_V=1, WB_DATA=0x1234, WB_EXC=0, MEM_stall never 1.
- LB, sign-extending: address 0x1003, rdata 0x00000000_80FF0000 (byte at off 3 = 0x80), response one cycle after accept. Required:
  - dmem_addr=0x1000.
  - Stall for 2 cycles.
  - WB_DATA=0xFFFFFFFF_FFFFFF80, WB_V=1 for exactly one cycle.
- SH with backpressure: address 0x2006, SR2=0xBEEF, ready held low 3 cycles. Required:
  - dmem_be=0xC0 and dmem_wdata=0xBEEF<<48, both stable while req_valid=1.
  - Retire on the accept cycle.
  - No WB_V during stall.
- LW misaligned at 0x3002. Required: no dmem_req_valid, WB_EXC=1, WB_V=1, WB_DATA=0, MEM_stall=0.
- LWU at 0x4004 with rdata 0xF0000001_00000000. Required: WB_DATA=0x00000000_F0000001.
- Reset asserted during WAIT of an LD, then a spurious rsp_valid. Required:
  - Outputs go to zero immediately.
  - After release, the FSM is in IDLE and the response is ignored: no WB_V.
